kmap_out_event_filter: RTL and testbench

//  Downstream stage for the 3-input OR (a|b|c) K-map output 'out'. Synchronises
//  the raw combinational output, rejects glitches shorter than STABLE_CYCLES,

---
 rtl/kmap_out_event_filter.sv | 134 +++++++++++++
 tb/tb_kmap_out_event_filter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/kmap_out_event_filter.sv
// Debounce, event counting and valid/ready event reporting for the OR-stage
// K-map output. The raw input is synchronised before any qualification.
module kmap_out_event_filter #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             aresetn,
   input  logic             in,
   output logic             filt_out,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [CNT_W-1:0] evt_count,
   output logic             evt_overflow,
   output logic [CNT_W-1:0] total_count
);

   localparam int QW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [QW-1:0] QMAX = QW'(STABLE_CYCLES - 1);

   typedef enum logic [1:0] {LOW, RISE_Q, HIGH, FALL_Q} qual_t;

   logic             s1;
   logic             in_s;
   qual_t            state;
   logic [QW-1:0]    qcnt;
   logic             qual_done;
   logic             rise;
   logic             xfer;
   logic [CNT_W-1:0] total_next;

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         s1   <= 1'b0;
         in_s <= 1'b0;
      end else begin
         s1   <= in;
         in_s <= s1;
      end
   end

   // qcnt is zero in LOW/HIGH, so qual_done there only holds when STABLE_CYCLES is 1
   always_comb begin
      qual_done  = (qcnt == QMAX);
      rise       = in_s && ((state == LOW) || (state == RISE_Q)) && qual_done;
      xfer       = evt_valid && evt_ready;
      total_next = (total_count == {CNT_W{1'b1}}) ? total_count : total_count + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state    <= LOW;
         qcnt     <= '0;
         filt_out <= 1'b0;
      end else begin
         case (state)
            LOW: begin
               if (in_s) begin
                  if (qual_done) begin
                     state    <= HIGH;
                     filt_out <= 1'b1;
                  end else begin
                     state <= RISE_Q;
                     qcnt  <= qcnt + QW'(1);
                  end
               end
            end
            RISE_Q: begin
               if (!in_s) begin
                  state <= LOW;
                  qcnt  <= '0;
               end else if (qual_done) begin
                  state    <= HIGH;
                  filt_out <= 1'b1;
                  qcnt     <= '0;
               end else begin
                  qcnt <= qcnt + QW'(1);
               end
            end
            HIGH: begin
               if (!in_s) begin
                  if (qual_done) begin
                     state    <= LOW;
                     filt_out <= 1'b0;
                  end else begin
                     state <= FALL_Q;
                     qcnt  <= qcnt + QW'(1);
                  end
               end
            end
            FALL_Q: begin
               if (in_s) begin
                  state <= HIGH;
                  qcnt  <= '0;
               end else if (qual_done) begin
                  state    <= LOW;
                  filt_out <= 1'b0;
                  qcnt     <= '0;
               end else begin
                  qcnt <= qcnt + QW'(1);
               end
            end
            default: begin
               state    <= LOW;
               qcnt     <= '0;
               filt_out <= 1'b0;
            end
         endcase
      end
   end

   // A stalled report keeps its count; a new event arriving then is counted but lost
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         evt_valid    <= 1'b0;
         evt_count    <= '0;
         evt_overflow <= 1'b0;
         total_count  <= '0;
      end else begin
         if (rise) begin
            total_count <= total_next;
            if (!evt_valid || evt_ready) begin
               evt_count <= total_next;
               evt_valid <= 1'b1;
            end else begin
               evt_overflow <= 1'b1;
            end
         end else if (xfer) begin
            evt_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_kmap_out_event_filter.sv
// Directed bench for kmap_out_event_filter: default instance plus a CNT_W=2
// instance for the saturation case, both driven from the same stimulus.
module tb_kmap_out_event_filter;

   logic       clk = 1'b0;
   logic       aresetn;
   logic       in;
   logic       evt_ready;
   logic       filt_out, evt_valid, evt_overflow;
   logic [7:0] evt_count, total_count;
   logic       sat_filt_out, sat_evt_valid, sat_evt_overflow;
   logic [1:0] sat_evt_count, sat_total_count;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   kmap_out_event_filter #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
      .clk          (clk),
      .aresetn      (aresetn),
      .in           (in),
      .filt_out     (filt_out),
      .evt_valid    (evt_valid),
      .evt_ready    (evt_ready),
      .evt_count    (evt_count),
      .evt_overflow (evt_overflow),
      .total_count  (total_count)
   );

   kmap_out_event_filter #(.STABLE_CYCLES(4), .CNT_W(2)) dut_sat (
      .clk          (clk),
      .aresetn      (aresetn),
      .in           (in),
      .filt_out     (sat_filt_out),
      .evt_valid    (sat_evt_valid),
      .evt_ready    (evt_ready),
      .evt_count    (sat_evt_count),
      .evt_overflow (sat_evt_overflow),
      .total_count  (sat_total_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      in      = 1'b0;
      tick();
      aresetn = 1'b1;
   endtask

   // in held high for n sampled edges, then low long enough for filt_out to settle
   task automatic pulse(input int n);
      in = 1'b1;
      repeat (n) tick();
      in = 1'b0;
      repeat (8) tick();
   endtask

   initial begin
      aresetn   = 1'b0;
      in        = 1'b0;
      evt_ready = 1'b1;
      #2;
      check_output("rst_filt",     32'(filt_out),     0);
      check_output("rst_valid",    32'(evt_valid),    0);
      check_output("rst_count",    32'(evt_count),    0);
      check_output("rst_overflow", 32'(evt_overflow), 0);
      check_output("rst_total",    32'(total_count),  0);

      // Held high: qualification completes on edge 5
      tick();
      aresetn = 1'b1;
      in      = 1'b1;
      repeat (5) tick();
      check_output("t1_filt_e4", 32'(filt_out), 0);
      tick();
      check_output("t1_filt_e5",  32'(filt_out),    1);
      check_output("t1_valid_e5", 32'(evt_valid),   1);
      check_output("t1_count_e5", 32'(evt_count),   1);
      check_output("t1_total_e5", 32'(total_count), 1);
      tick();
      check_output("t1_valid_e6", 32'(evt_valid), 0);
      in = 1'b0;
      repeat (6) tick();
      check_output("t1_fall_filt",  32'(filt_out),    0);
      check_output("t1_fall_total", 32'(total_count), 1);

      // Glitch of 3 samples is dropped, 4 samples qualifies
      do_reset();
      pulse(3);
      check_output("t2_short_total", 32'(total_count), 0);
      check_output("t2_short_valid", 32'(evt_valid),   0);
      in = 1'b1;
      repeat (4) tick();
      in = 1'b0;
      check_output("t2_filt_e3", 32'(filt_out), 0);
      repeat (2) tick();
      check_output("t2_filt_e5", 32'(filt_out), 1);
      repeat (4) tick();
      check_output("t2_filt_e9",  32'(filt_out),    0);
      check_output("t2_total",    32'(total_count), 1);

      // Stalled consumer: second event overflows
      do_reset();
      evt_ready = 1'b0;
      pulse(4);
      check_output("t3_valid1", 32'(evt_valid), 1);
      check_output("t3_ovf1",   32'(evt_overflow), 0);
      pulse(4);
      check_output("t3_count",  32'(evt_count),    1);
      check_output("t3_valid2", 32'(evt_valid),    1);
      check_output("t3_ovf2",   32'(evt_overflow), 1);
      check_output("t3_total",  32'(total_count),  2);
      evt_ready = 1'b1;
      tick();
      check_output("t3_valid_after", 32'(evt_valid),    0);
      check_output("t3_ovf_sticky",  32'(evt_overflow), 1);

      // Transfer and new event on the same edge
      do_reset();
      evt_ready = 1'b0;
      pulse(4);
      check_output("t4_pending", 32'(evt_count), 1);
      in = 1'b1;
      repeat (4) tick();
      in = 1'b0;
      tick();
      evt_ready = 1'b1;
      tick();
      check_output("t4_count", 32'(evt_count),    2);
      check_output("t4_valid", 32'(evt_valid),    1);
      check_output("t4_ovf",   32'(evt_overflow), 0);
      tick();
      check_output("t4_valid_done", 32'(evt_valid), 0);

      // Saturating 2-bit counters
      do_reset();
      evt_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in = 1'b1;
         repeat (4) tick();
         in = 1'b0;
         repeat (2) tick();
         check_output($sformatf("t5_valid_%0d", i), 32'(sat_evt_valid), 1);
         check_output($sformatf("t5_count_%0d", i), 32'(sat_evt_count),
                      (i < 3) ? i + 1 : 3);
         repeat (6) tick();
      end
      check_output("t5_total", 32'(sat_total_count), 3);
      check_output("t5_ovf",   32'(sat_evt_overflow), 0);

      // Async reset mid-qualification with a report pending
      do_reset();
      evt_ready = 1'b0;
      pulse(4);
      in = 1'b1;
      repeat (3) tick();
      aresetn = 1'b0;
      #2;
      check_output("t6_rst_filt",  32'(filt_out),     0);
      check_output("t6_rst_valid", 32'(evt_valid),    0);
      check_output("t6_rst_count", 32'(evt_count),    0);
      check_output("t6_rst_total", 32'(total_count),  0);
      check_output("t6_rst_ovf",   32'(evt_overflow), 0);
      tick();
      aresetn   = 1'b1;
      evt_ready = 1'b1;
      repeat (5) tick();
      check_output("t6_filt_e4", 32'(filt_out), 0);
      tick();
      check_output("t6_valid_e5", 32'(evt_valid), 1);
      check_output("t6_count_e5", 32'(evt_count), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
